// File: rtl/tone_if.sv
// Tone decoder bus: configuration and sound line in, classification results out.
interface tone_if;
    logic [15:0] ticks_per_milli;
    logic        sound;
    logic        tone_valid;
    logic [1:0]  tone_idx;
    logic        silent;
    logic        tone_change;

    // Source side: provides timing base and sound line, observes the result.
    modport master (
        output ticks_per_milli,
        output sound,
        input  tone_valid,
        input  tone_idx,
        input  silent,
        input  tone_change
    );

    // Decoder side.
    modport slave (
        input  ticks_per_milli,
        input  sound,
        output tone_valid,
        output tone_idx,
        output silent,
        output tone_change
    );
endinterface

// File: rtl/tone_decoder.sv
// Measures the period of the game's square-wave sound line and classifies it as one
// of the four game tones (196/262/330/784 Hz) or silence.
module tone_decoder #(
    parameter int unsigned MATCH_COUNT = 3,
    parameter int unsigned SILENCE_MS  = 20,
    parameter int unsigned TOL_SHIFT   = 4
) (
    input  logic  clk,
    input  logic  rst,
    tone_if.slave bus
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned RUN_W = $clog2(MATCH_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_MEAS, S_CLASS, S_UPD} state_t;

    state_t           state;
    logic             s_q;
    logic             sil_q;
    logic             disc;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] p_reg;
    logic [1:0]       k;
    logic [3:0]       hit;
    logic [1:0]       run_idx;
    logic [RUN_W-1:0] run_cnt;
    logic             tone_valid_q;
    logic [1:0]       tone_idx_q;
    logic             silent_q;
    logic             tone_change_q;

    logic             edge_c;
    logic [31:0]      tps_c;
    logic [31:0]      tol_c;
    logic [31:0]      tone_c;
    logic [31:0]      prod_c;
    logic [31:0]      diff_c;
    logic             hit_c;
    logic [31:0]      sil_prod_c;
    logic [CNT_W-1:0] sil_thr_c;
    logic             miss_c;
    logic [1:0]       idx_c;
    logic [RUN_W-1:0] run_nxt_c;
    logic [1:0]       run_idx_nxt_c;
    logic             valid_nxt_c;

    // Rising edge, one-tone-per-cycle tolerance test and silence threshold.
    always_comb begin
        edge_c = bus.sound & ~s_q;
        tps_c  = 32'(bus.ticks_per_milli) * 32'd1000;
        tol_c  = tps_c >> TOL_SHIFT;
        case (k)
            2'd0:    tone_c = 32'd196;
            2'd1:    tone_c = 32'd262;
            2'd2:    tone_c = 32'd330;
            default: tone_c = 32'd784;
        endcase
        prod_c     = 32'(p_reg) * tone_c;
        diff_c     = (prod_c >= tps_c) ? (prod_c - tps_c) : (tps_c - prod_c);
        hit_c      = (diff_c <= tol_c);
        sil_prod_c = 32'(bus.ticks_per_milli) * 32'(SILENCE_MS);
        sil_thr_c  = (sil_prod_c > 32'(CNT_MAX)) ? CNT_MAX : sil_prod_c[CNT_W-1:0];
    end

    // Pick the lowest hitting tone and compute the next run tracker values.
    always_comb begin
        idx_c = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (hit[i]) idx_c = 2'(i);
        end
        miss_c        = disc | ~(|hit);
        run_nxt_c     = run_cnt;
        run_idx_nxt_c = run_idx;
        if (miss_c) begin
            run_nxt_c = '0;
        end else if ((idx_c == run_idx) && (run_cnt != '0)) begin
            run_nxt_c = (run_cnt == RUN_W'(MATCH_COUNT)) ? run_cnt : run_cnt + RUN_W'(1);
        end else begin
            run_idx_nxt_c = idx_c;
            run_nxt_c     = RUN_W'(1);
        end
        valid_nxt_c = (run_nxt_c == RUN_W'(MATCH_COUNT));
    end

    // Period counter, measurement FSM, run tracking and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            s_q           <= 1'b0;
            sil_q         <= 1'b0;
            disc          <= 1'b0;
            per_cnt       <= '0;
            p_reg         <= '0;
            k             <= 2'd0;
            hit           <= 4'd0;
            run_idx       <= 2'd0;
            run_cnt       <= '0;
            tone_valid_q  <= 1'b0;
            tone_idx_q    <= 2'd0;
            silent_q      <= 1'b1;
            tone_change_q <= 1'b0;
        end else begin
            s_q           <= bus.sound;
            tone_change_q <= 1'b0;
            if (edge_c) begin
                per_cnt <= CNT_W'(1);
            end else if (per_cnt != CNT_MAX) begin
                per_cnt <= per_cnt + CNT_W'(1);
            end
            sil_q <= ~edge_c & (per_cnt >= sil_thr_c);

            if (sil_q && !edge_c) begin
                silent_q     <= 1'b1;
                tone_valid_q <= 1'b0;
                run_cnt      <= '0;
                state        <= S_IDLE;
            end else begin
                if (edge_c) silent_q <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (edge_c) state <= S_MEAS;
                    end
                    S_MEAS: begin
                        if (edge_c && (per_cnt != CNT_MAX)) begin
                            p_reg <= per_cnt;
                            k     <= 2'd0;
                            disc  <= 1'b0;
                            state <= S_CLASS;
                        end
                    end
                    S_CLASS: begin
                        hit[k] <= hit_c;
                        if (edge_c) disc <= 1'b1;
                        k <= k + 2'd1;
                        if (k == 2'd3) state <= S_UPD;
                    end
                    S_UPD: begin
                        run_cnt       <= run_nxt_c;
                        run_idx       <= run_idx_nxt_c;
                        tone_valid_q  <= valid_nxt_c;
                        if (valid_nxt_c) tone_idx_q <= run_idx_nxt_c;
                        tone_change_q <= valid_nxt_c & ~tone_valid_q;
                        state         <= S_MEAS;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.tone_valid  = tone_valid_q;
    assign bus.tone_idx    = tone_idx_q;
    assign bus.silent      = silent_q;
    assign bus.tone_change = tone_change_q;
endmodule
